// File: rtl/crossing_pkg.sv
// Shared types for the Thevenin/Norton crossing sequencer: phase states,
// light command codes and the per-light change vector layout.
package crossing_pkg;

  typedef enum logic [3:0] {
    INIT      = 4'd0,
    TH_GREEN  = 4'd1,
    TH_YELLOW = 4'd2,
    CLR1      = 4'd3,
    N_GREEN   = 4'd4,
    N_YELLOW  = 4'd5,
    CLR2      = 4'd6,
    PED       = 4'd7,
    CLR3      = 4'd8
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam int CH_TH        = 0;
  localparam int CH_NN        = 1;
  localparam int CH_NS        = 2;
  localparam int CH_TURN_TH   = 3;
  localparam int CH_TURN_NN_L = 4;
  localparam int CH_TURN_NN_R = 5;
  localparam int CH_WALK_TH1  = 6;
  localparam int CH_WALK_TH2  = 7;
  localparam int CH_WALK_N    = 8;
  localparam int N_LIGHTS     = 9;

  typedef struct packed {
    logic       set_lights;
    logic [1:0] veh_th;
    logic [1:0] veh_nn;
    logic [1:0] veh_ns;
    logic       turn_th;
    logic       turn_nn_l;
    logic       turn_nn_r;
    logic       walk_th1;
    logic       walk_th2;
    logic       walk_n;
  } light_cmd_t;

  // Everything not listed for a state stays red / off.
  function automatic light_cmd_t lights_for(state_t s);
    light_cmd_t c;
    c = '0;
    case (s)
      INIT: c.set_lights = 1'b1;
      TH_GREEN: begin
        c.veh_th  = GREEN;
        c.turn_th = 1'b1;
      end
      TH_YELLOW: c.veh_th = YELLOW;
      N_GREEN: begin
        c.veh_nn    = GREEN;
        c.veh_ns    = GREEN;
        c.turn_nn_l = 1'b1;
        c.turn_nn_r = 1'b1;
      end
      N_YELLOW: begin
        c.veh_nn = YELLOW;
        c.veh_ns = YELLOW;
      end
      PED: begin
        c.walk_th1 = 1'b1;
        c.walk_th2 = 1'b1;
        c.walk_n   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [N_LIGHTS-1:0] change_mask(light_cmd_t o, light_cmd_t n);
    logic [N_LIGHTS-1:0] m;
    m               = '0;
    m[CH_TH]        = (o.veh_th != n.veh_th);
    m[CH_NN]        = (o.veh_nn != n.veh_nn);
    m[CH_NS]        = (o.veh_ns != n.veh_ns);
    m[CH_TURN_TH]   = (o.turn_th != n.turn_th);
    m[CH_TURN_NN_L] = (o.turn_nn_l != n.turn_nn_l);
    m[CH_TURN_NN_R] = (o.turn_nn_r != n.turn_nn_r);
    m[CH_WALK_TH1]  = (o.walk_th1 != n.walk_th1);
    m[CH_WALK_TH2]  = (o.walk_th2 != n.walk_th2);
    m[CH_WALK_N]    = (o.walk_n != n.walk_n);
    return m;
  endfunction

endpackage

// File: rtl/crossing_phase_controller_phase_timer.sv
// Millisecond timebase: prescaler plus a 16-bit saturating ms counter that
// restarts from zero whenever the phase changes.
module phase_timer #(
  parameter int CLK_DIV = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        en,
  input  logic        clear,
  output logic [15:0] ms_cnt
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PRESC_LAST);

  // Clearing the prescaler with ms_cnt makes every phase a whole number of ms.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (en) begin
      if (clear) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else begin
        presc <= wrap ? '0 : presc + 1'b1;
        if (wrap && ms_cnt != 16'hFFFF)
          ms_cnt <= ms_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/crossing_phase_controller.sv
// Phase sequencer for the Thevenin/Norton crossing: sensor/button sync,
// demand latches, phase FSM and registered light commands with change pulses.
module crossing_phase_controller
  import crossing_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int TH_MIN_MS = 10000,
  parameter int TH_MAX_MS = 30000,
  parameter int N_MIN_MS  = 8000,
  parameter int N_MAX_MS  = 20000,
  parameter int YELLOW_MS = 3000,
  parameter int ALLRED_MS = 1000,
  parameter int PED_MS    = 8000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic       sens_th,
  input  logic       sens_nn,
  input  logic       sens_ns,
  input  logic       ped_nn,
  input  logic       ped_ns,
  input  logic       ped_th,
  output logic       set_lights,
  output logic [1:0] veh_th,
  output logic [1:0] veh_nn,
  output logic [1:0] veh_ns,
  output logic       turn_th,
  output logic       turn_nn_l,
  output logic       turn_nn_r,
  output logic       walk_th1,
  output logic       walk_th2,
  output logic       walk_n,
  output logic [8:0] change
);

  localparam logic [15:0] TH_MIN_T = 16'(TH_MIN_MS);
  localparam logic [15:0] TH_MAX_T = 16'(TH_MAX_MS);
  localparam logic [15:0] N_MIN_T  = 16'(N_MIN_MS);
  localparam logic [15:0] N_MAX_T  = 16'(N_MAX_MS);
  localparam logic [15:0] YEL_T    = 16'(YELLOW_MS);
  localparam logic [15:0] ALLRED_T = 16'(ALLRED_MS);
  localparam logic [15:0] PED_T    = 16'(PED_MS);

  state_t      state, state_nxt;
  light_cmd_t  cmd_q, cmd_nxt;
  logic [15:0] ms_cnt;
  logic        transition;

  logic [5:0] sync1, sync2;
  logic [2:0] btn_prev;
  logic [2:0] btn_edge;
  logic       sens_th_s, sens_nn_s, sens_ns_s;
  logic       any_btn;
  logic       ped_req, n_dem;
  logic       enter_ped, enter_n;

  // Bits 0..2 sensors (th, nn, ns), bits 3..5 buttons (nn, ns, th).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_prev <= '0;
    end else begin
      sync1    <= {ped_th, ped_ns, ped_nn, sens_ns, sens_nn, sens_th};
      sync2    <= sync1;
      btn_prev <= sync2[5:3];
    end
  end

  assign sens_th_s = sync2[0];
  assign sens_nn_s = sync2[1];
  assign sens_ns_s = sync2[2];
  assign btn_edge  = sync2[5:3] & ~btn_prev;
  assign any_btn   = |btn_edge;

  assign enter_ped = (state_nxt == PED) && (state != PED);
  assign enter_n   = (state_nxt == N_GREEN) && (state != N_GREEN);

  // A new request in the same cycle as the clear must not be lost.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ped_req <= 1'b0;
      n_dem   <= 1'b0;
    end else begin
      if (any_btn)
        ped_req <= 1'b1;
      else if (enter_ped)
        ped_req <= 1'b0;

      if (sens_nn_s || sens_ns_s || any_btn)
        n_dem <= 1'b1;
      else if (enter_n)
        n_dem <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        INIT:      if (ms_cnt >= ALLRED_T) state_nxt = TH_GREEN;
        TH_GREEN:  if (ms_cnt >= TH_MIN_T && n_dem && (!sens_th_s || ms_cnt >= TH_MAX_T))
                     state_nxt = TH_YELLOW;
        TH_YELLOW: if (ms_cnt >= YEL_T) state_nxt = CLR1;
        CLR1:      if (ms_cnt >= ALLRED_T) state_nxt = N_GREEN;
        N_GREEN:   if (ms_cnt >= N_MIN_T && ((!sens_nn_s && !sens_ns_s) || ms_cnt >= N_MAX_T))
                     state_nxt = N_YELLOW;
        N_YELLOW:  if (ms_cnt >= YEL_T) state_nxt = CLR2;
        CLR2:      if (ms_cnt >= ALLRED_T) state_nxt = ped_req ? PED : TH_GREEN;
        PED:       if (ms_cnt >= PED_T) state_nxt = CLR3;
        CLR3:      if (ms_cnt >= ALLRED_T) state_nxt = TH_GREEN;
        default:   state_nxt = INIT;
      endcase
    end
  end

  assign transition = en && (state_nxt != state);
  assign cmd_nxt    = lights_for(state_nxt);

  phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .CLK    (CLK),
    .reset  (reset),
    .en     (en),
    .clear  (transition),
    .ms_cnt (ms_cnt)
  );

  // Commands are registered from the next state so each light and its
  // change bit update on the same edge as the phase.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= INIT;
      cmd_q  <= lights_for(INIT);
      change <= '0;
    end else if (en) begin
      state  <= state_nxt;
      cmd_q  <= cmd_nxt;
      change <= change_mask(cmd_q, cmd_nxt);
    end else begin
      change <= '0;
    end
  end

  assign set_lights = cmd_q.set_lights;
  assign veh_th     = cmd_q.veh_th;
  assign veh_nn     = cmd_q.veh_nn;
  assign veh_ns     = cmd_q.veh_ns;
  assign turn_th    = cmd_q.turn_th;
  assign turn_nn_l  = cmd_q.turn_nn_l;
  assign turn_nn_r  = cmd_q.turn_nn_r;
  assign walk_th1   = cmd_q.walk_th1;
  assign walk_th2   = cmd_q.walk_th2;
  assign walk_n     = cmd_q.walk_n;

endmodule

// File: tb/tb_crossing_phase_controller.sv
// Directed bench for crossing_phase_controller with scaled-down timings
// (2 cycles per ms; each phase lasts threshold_ms*2+1 cycles edge to edge).
module tb_crossing_phase_controller;

  localparam int CLK_DIV   = 2;
  localparam int TH_MIN_MS = 100;
  localparam int TH_MAX_MS = 300;
  localparam int N_MIN_MS  = 80;
  localparam int N_MAX_MS  = 200;
  localparam int YELLOW_MS = 30;
  localparam int ALLRED_MS = 10;
  localparam int PED_MS    = 80;

  localparam int PH_INIT = 0, PH_RED = 1, PH_THG = 2, PH_THY = 3,
                 PH_NG = 4, PH_NY = 5, PH_PED = 6;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       sens_th = 1'b0, sens_nn = 1'b0, sens_ns = 1'b0;
  logic       ped_nn = 1'b0, ped_ns = 1'b0, ped_th = 1'b0;
  logic       set_lights;
  logic [1:0] veh_th, veh_nn, veh_ns;
  logic       turn_th, turn_nn_l, turn_nn_r;
  logic       walk_th1, walk_th2, walk_n;
  logic [8:0] change;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  crossing_phase_controller #(
    .CLK_DIV   (CLK_DIV),
    .TH_MIN_MS (TH_MIN_MS),
    .TH_MAX_MS (TH_MAX_MS),
    .N_MIN_MS  (N_MIN_MS),
    .N_MAX_MS  (N_MAX_MS),
    .YELLOW_MS (YELLOW_MS),
    .ALLRED_MS (ALLRED_MS),
    .PED_MS    (PED_MS)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .en         (en),
    .sens_th    (sens_th),
    .sens_nn    (sens_nn),
    .sens_ns    (sens_ns),
    .ped_nn     (ped_nn),
    .ped_ns     (ped_ns),
    .ped_th     (ped_th),
    .set_lights (set_lights),
    .veh_th     (veh_th),
    .veh_nn     (veh_nn),
    .veh_ns     (veh_ns),
    .turn_th    (turn_th),
    .turn_nn_l  (turn_nn_l),
    .turn_nn_r  (turn_nn_r),
    .walk_th1   (walk_th1),
    .walk_th2   (walk_th2),
    .walk_n     (walk_n),
    .change     (change)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic int obs_phase();
    if (set_lights)            return PH_INIT;
    else if (walk_n)           return PH_PED;
    else if (veh_th == 2'b10)  return PH_THG;
    else if (veh_th == 2'b01)  return PH_THY;
    else if (veh_nn == 2'b10)  return PH_NG;
    else if (veh_nn == 2'b01)  return PH_NY;
    else                       return PH_RED;
  endfunction

  // Conflicting greens: Thevenin vs Norton, or any vehicle/turn vs walk.
  always @(negedge CLK) begin
    logic th_go, n_go, walk_go;
    th_go   = (veh_th == 2'b10) || turn_th;
    n_go    = (veh_nn == 2'b10) || (veh_ns == 2'b10) || turn_nn_l || turn_nn_r;
    walk_go = walk_th1 || walk_th2 || walk_n;
    chk("safety", {31'd0, (th_go && n_go) || ((th_go || n_go) && walk_go)}, 32'd0);
  end

  task automatic wait_phase(input string tag, input int ph, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (obs_phase() == ph) begin
        t = cyc;
        return;
      end
    end
    chk({tag, "_timeout"}, obs_phase(), ph);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic do_reset(output int t0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7, nbad;

    // Reset values while reset is held
    repeat (2) @(negedge CLK);
    chk("rst_set_lights", set_lights, 1);
    chk("rst_veh", {veh_th, veh_nn, veh_ns}, 0);
    chk("rst_turn_walk", {turn_th, turn_nn_l, turn_nn_r, walk_th1, walk_th2, walk_n}, 0);
    chk("rst_change", change, 0);

    // A: power-up, no demand
    do_reset(t0);
    wait_phase("a_thg", PH_THG, 200, t1);
    chk("a_init_len", t1 - t0, ALLRED_MS * CLK_DIV + 1);
    chk("a_change_init_exit", change, 9'b000001001);
    chk("a_turn_th", turn_th, 1);
    chk("a_set_lights_off", set_lights, 0);
    @(negedge CLK);
    chk("a_change_one_cycle", change, 0);
    repeat (1000) @(negedge CLK);
    chk("a_rest_th", obs_phase(), PH_THG);

    // B: Norton demand, sens_th low, drop sens_nn mid Norton green
    do_reset(t0);
    wait_phase("b_thg", PH_THG, 200, t1);
    wait_until(t1 + 20 * CLK_DIV);
    sens_nn = 1'b1;
    wait_phase("b_thy", PH_THY, 1000, t2);
    chk("b_th_len", t2 - t1, TH_MIN_MS * CLK_DIV + 1);
    chk("b_change_thy", change, 9'b000001001);
    wait_phase("b_clr1", PH_RED, 500, t3);
    chk("b_yel_len", t3 - t2, YELLOW_MS * CLK_DIV + 1);
    wait_phase("b_ng", PH_NG, 500, t4);
    chk("b_clr1_len", t4 - t3, ALLRED_MS * CLK_DIV + 1);
    chk("b_change_ng", change, 9'b000110110);
    chk("b_ns_green", veh_ns, 2'b10);
    wait_until(t4 + 120 * CLK_DIV);
    sens_nn = 1'b0;
    wait_phase("b_ny", PH_NY, 1000, t5);
    chk("b_ng_len", t5 - t4, 120 * CLK_DIV + 3);
    wait_phase("b_clr2", PH_RED, 500, t6);
    chk("b_ny_len", t6 - t5, YELLOW_MS * CLK_DIV + 1);
    wait_phase("b_back_th", PH_THG, 500, t7);
    chk("b_clr2_len", t7 - t6, ALLRED_MS * CLK_DIV + 1);

    // C: both directions busy -> max greens
    do_reset(t0);
    wait_phase("c_thg", PH_THG, 200, t1);
    sens_th = 1'b1;
    sens_nn = 1'b1;
    wait_phase("c_thy", PH_THY, 2000, t2);
    chk("c_th_max_len", t2 - t1, TH_MAX_MS * CLK_DIV + 1);
    wait_phase("c_clr1", PH_RED, 500, t3);
    wait_phase("c_ng", PH_NG, 500, t4);
    wait_phase("c_ny", PH_NY, 2000, t5);
    chk("c_n_max_len", t5 - t4, N_MAX_MS * CLK_DIV + 1);
    sens_th = 1'b0;
    sens_nn = 1'b0;

    // D: pedestrian phase, second press inside PED
    do_reset(t0);
    wait_phase("d_thg", PH_THG, 200, t1);
    wait_until(t1 + 20 * CLK_DIV);
    ped_ns = 1'b1;
    repeat (CLK_DIV) @(negedge CLK);
    ped_ns = 1'b0;
    wait_phase("d_thy", PH_THY, 1000, t2);
    chk("d_th_len", t2 - t1, TH_MIN_MS * CLK_DIV + 1);
    wait_phase("d_ng", PH_NG, 500, t3);
    wait_phase("d_ny", PH_NY, 1000, t4);
    chk("d_n_min_len", t4 - t3, N_MIN_MS * CLK_DIV + 1);
    wait_phase("d_clr2", PH_RED, 500, t5);
    wait_phase("d_ped", PH_PED, 500, t6);
    chk("d_clr2_len", t6 - t5, ALLRED_MS * CLK_DIV + 1);
    chk("d_change_ped", change, 9'b111000000);
    chk("d_walk_all", {walk_th1, walk_th2, walk_n}, 3'b111);
    wait_until(t6 + 20 * CLK_DIV);
    ped_th = 1'b1;
    repeat (CLK_DIV) @(negedge CLK);
    ped_th = 1'b0;
    wait_phase("d_clr3", PH_RED, 1000, t7);
    chk("d_ped_len", t7 - t6, PED_MS * CLK_DIV + 1);
    wait_phase("d_thg2", PH_THG, 500, t1);
    chk("d_clr3_len", t1 - t7, ALLRED_MS * CLK_DIV + 1);
    wait_phase("d_ny2", PH_NY, 2000, t2);
    wait_phase("d_clr2b", PH_RED, 500, t3);
    wait_phase("d_ped2", PH_PED, 500, t4);
    chk("d_ped2_clr2_len", t4 - t3, ALLRED_MS * CLK_DIV + 1);

    // E: freeze in mid Thevenin yellow
    do_reset(t0);
    wait_phase("e_thg", PH_THG, 200, t1);
    sens_nn = 1'b1;
    wait_phase("e_thy", PH_THY, 1000, t2);
    sens_nn = 1'b0;
    wait_until(t2 + 20);
    en = 1'b0;
    nbad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (change != 9'd0 || veh_th != 2'b01 || veh_nn != 2'b00) nbad++;
    end
    en = 1'b1;
    chk("e_frozen_cycles_bad", nbad, 0);
    wait_phase("e_clr1", PH_RED, 500, t3);
    chk("e_yel_len_with_freeze", t3 - t2, YELLOW_MS * CLK_DIV + 1 + 100);

    // F: asynchronous reset mid Norton green
    do_reset(t0);
    wait_phase("f_thg", PH_THG, 200, t1);
    sens_nn = 1'b1;
    wait_phase("f_ng", PH_NG, 1000, t2);
    repeat (50) @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("f_async_veh_red", {veh_th, veh_nn, veh_ns}, 0);
    chk("f_async_turns_off", {turn_nn_l, turn_nn_r}, 0);
    chk("f_async_set_lights", set_lights, 1);
    sens_nn = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    t0 = cyc;
    chk("f_init_phase", obs_phase(), PH_INIT);
    wait_phase("f_thg2", PH_THG, 200, t1);
    chk("f_init_len", t1 - t0, ALLRED_MS * CLK_DIV + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
